// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Purpose  : Launches one of four datapath programs and supervises the run
//            (INIT pulse, run-cycle timeout, completion ack).
// Options  : PROGRAM_SEQUENCER_CYCLE_COUNT_EN exposes the run counter on
//            cycle_count (otherwise cycle_count is tied to zero).
// Revision : 1.0 - initial release
// ============================================================================
module program_sequencer #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter logic [15:0] TIMEOUT     = 16'd60000,
    parameter logic [15:0] PROG0_PC    = 16'd0,
    parameter logic [15:0] PROG1_PC    = 16'd116,
    parameter logic [15:0] PROG2_PC    = 16'd172,
    parameter logic [15:0] PROG3_PC    = 16'd259
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        req,
    input  logic [1:0]  prog_sel,
    input  logic        dp_done,
    output logic        dp_start,
    output logic [15:0] start_pc,
    output logic        busy,
    output logic        ack,
    output logic        timeout_err,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INIT   = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [3:0] c_INIT_LAST = 4'(INIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_sel;
    logic [3:0]  r_init_cnt;
    logic [15:0] r_run_cnt;
    logic        r_timeout_err;
    logic        r_req_low_seen;

    logic        w_launch;
    logic        w_timeout_hit;
    logic [15:0] w_run_next;

    assign w_run_next = (r_run_cnt == 16'hFFFF) ? r_run_cnt : r_run_cnt + 16'd1;

    // A launch needs req seen low in IDLE since the previous launch, so a
    // host that holds req across ack does not retrigger the same program.
    always_comb begin
        w_state_next  = r_state;
        w_launch      = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req && r_req_low_seen) begin
                    w_launch     = 1'b1;
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                if (r_init_cnt == c_INIT_LAST) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (dp_done) begin
                    w_state_next = S_FINISH;
                end else if (w_run_next >= TIMEOUT) begin
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        dp_start = (r_state == S_INIT);
        busy     = (r_state != S_IDLE);
        ack      = (r_state == S_FINISH);
        case (r_sel)
            2'd0:    start_pc = PROG0_PC;
            2'd1:    start_pc = PROG1_PC;
            2'd2:    start_pc = PROG2_PC;
            default: start_pc = PROG3_PC;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_sel          <= 2'd0;
            r_init_cnt     <= 4'd0;
            r_run_cnt      <= 16'd0;
            r_timeout_err  <= 1'b0;
            r_req_low_seen <= 1'b1;
        end else begin
            r_state <= w_state_next;

            if (w_launch) begin
                r_sel          <= prog_sel;
                r_run_cnt      <= 16'd0;
                r_timeout_err  <= 1'b0;
                r_req_low_seen <= 1'b0;
            end else if (r_state == S_IDLE && !req) begin
                r_req_low_seen <= 1'b1;
            end

            if (r_state == S_INIT) begin
                r_init_cnt <= r_init_cnt + 4'd1;
            end else begin
                r_init_cnt <= 4'd0;
            end

            if (r_state == S_RUN) begin
                r_run_cnt <= w_run_next;
            end

            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;

`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
    assign cycle_count = r_run_cnt;
`else
    assign cycle_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Purpose  : Directed self-checking bench for program_sequencer
//            (INIT_CYCLES=2, TIMEOUT=20).
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

`ifdef PROGRAM_SEQUENCER_CYCLE_COUNT_EN
    localparam bit c_CC_EN = 1'b1;
`else
    localparam bit c_CC_EN = 1'b0;
`endif

    logic        CLK;
    logic        reset_n;
    logic        req;
    logic [1:0]  prog_sel;
    logic        dp_done;
    logic        dp_start;
    logic [15:0] start_pc;
    logic        busy;
    logic        ack;
    logic        timeout_err;
    logic [15:0] cycle_count;

    int checks = 0;
    int errors = 0;

    program_sequencer #(
        .INIT_CYCLES (2),
        .TIMEOUT     (16'd20)
    ) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .req         (req),
        .prog_sel    (prog_sel),
        .dp_done     (dp_done),
        .dp_start    (dp_start),
        .start_pc    (start_pc),
        .busy        (busy),
        .ack         (ack),
        .timeout_err (timeout_err),
        .cycle_count (cycle_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 1'b0;
        prog_sel = 2'd0;
        dp_done  = 1'b0;

        // ---------------- reset state ----------------
        tick(2);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_dp_start", 32'(dp_start),    32'd0);
        check("rst_ack",      32'(ack),         32'd0);
        check("rst_tmo",      32'(timeout_err), 32'd0);
        check("rst_cc",       32'(cycle_count), 32'd0);
        check("rst_pc",       32'(start_pc),    32'd0);
        reset_n = 1'b1;
        tick(1);
        check("idle_busy",    32'(busy),        32'd0);

        // ---------------- normal run, program 2 ----------------
        req = 1'b1; prog_sel = 2'd2;
        tick(1);
        check("n_init1_start", 32'(dp_start), 32'd1);
        check("n_init1_pc",    32'(start_pc), 32'd172);
        check("n_init1_busy",  32'(busy),     32'd1);
        req = 1'b0;
        tick(1);
        check("n_init2_start", 32'(dp_start), 32'd1);
        tick(1);
        check("n_run1_start",  32'(dp_start), 32'd0);
        check("n_run1_busy",   32'(busy),     32'd1);
        tick(9);
        check("n_run10_ack",   32'(ack),      32'd0);
        dp_done = 1'b1;
        tick(1);
        dp_done = 1'b0;
        check("n_fin_ack",     32'(ack),         32'd1);
        check("n_fin_cc",      32'(cycle_count), c_CC_EN ? 32'd10 : 32'd0);
        check("n_fin_tmo",     32'(timeout_err), 32'd0);
        tick(1);
        check("n_idle_ack",    32'(ack),         32'd0);
        check("n_idle_busy",   32'(busy),        32'd0);
        check("n_idle_pc",     32'(start_pc),    32'd172);
        check("n_idle_cc",     32'(cycle_count), c_CC_EN ? 32'd10 : 32'd0);
        tick(1);

        // ---------------- timeout run, program 1, dp_done early in INIT ----------------
        req = 1'b1; prog_sel = 2'd1;
        tick(1);
        check("t_init_pc",     32'(start_pc), 32'd116);
        req = 1'b0; dp_done = 1'b1;
        tick(1);
        check("t_init2_start", 32'(dp_start), 32'd1);
        tick(1);
        dp_done = 1'b0;
        check("t_run1_busy",   32'(busy),     32'd1);
        check("t_run1_ack",    32'(ack),      32'd0);
        check("t_run1_start",  32'(dp_start), 32'd0);
        tick(19);
        check("t_run20_busy",  32'(busy),        32'd1);
        check("t_run20_ack",   32'(ack),         32'd0);
        check("t_run20_tmo",   32'(timeout_err), 32'd0);
        tick(1);
        check("t_fin_ack",     32'(ack),         32'd1);
        check("t_fin_tmo",     32'(timeout_err), 32'd1);
        check("t_fin_cc",      32'(cycle_count), c_CC_EN ? 32'd20 : 32'd0);
        tick(1);
        check("t_idle_ack",    32'(ack),         32'd0);
        check("t_idle_tmo",    32'(timeout_err), 32'd1);
        tick(1);
        check("t_idle2_tmo",   32'(timeout_err), 32'd1);

        // ---------------- tie: dp_done on RUN cycle 20, program 3 ----------------
        req = 1'b1; prog_sel = 2'd3;
        tick(1);
        check("tie_init_tmo",  32'(timeout_err), 32'd0);
        check("tie_init_pc",   32'(start_pc),    32'd259);
        check("tie_init_cc",   32'(cycle_count), 32'd0);
        req = 1'b0;
        tick(2);
        tick(19);
        dp_done = 1'b1;
        tick(1);
        dp_done = 1'b0;
        check("tie_fin_ack",   32'(ack),         32'd1);
        check("tie_fin_tmo",   32'(timeout_err), 32'd0);
        check("tie_fin_cc",    32'(cycle_count), c_CC_EN ? 32'd20 : 32'd0);
        tick(1);
        check("tie_idle_busy", 32'(busy),        32'd0);
        tick(1);

        // ---------------- held req across ack ----------------
        req = 1'b1; prog_sel = 2'd0;
        tick(1);
        check("h_init_pc",     32'(start_pc), 32'd0);
        check("h_init_start",  32'(dp_start), 32'd1);
        tick(2);
        dp_done = 1'b1;
        tick(1);
        dp_done = 1'b0; prog_sel = 2'd1;
        check("h_fin_ack",     32'(ack),      32'd1);
        tick(1);
        check("h_idle1_busy",  32'(busy),     32'd0);
        tick(1);
        check("h_idle2_busy",  32'(busy),     32'd0);
        check("h_idle2_start", 32'(dp_start), 32'd0);
        check("h_idle2_pc",    32'(start_pc), 32'd0);
        tick(1);
        check("h_idle3_busy",  32'(busy),     32'd0);
        req = 1'b0;
        tick(1);
        check("h_low_busy",    32'(busy),     32'd0);
        req = 1'b1;
        tick(1);
        check("h_relaunch_start", 32'(dp_start), 32'd1);
        check("h_relaunch_pc",    32'(start_pc), 32'd116);

        // ---------------- reset in RUN cycle 5 ----------------
        req = 1'b0;
        tick(2);
        tick(4);
        check("r_run5_busy",   32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("r_async_busy",  32'(busy),        32'd0);
        check("r_async_start", 32'(dp_start),    32'd0);
        check("r_async_ack",   32'(ack),         32'd0);
        check("r_async_pc",    32'(start_pc),    32'd0);
        check("r_async_cc",    32'(cycle_count), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        check("r_post_busy",   32'(busy), 32'd0);
        check("r_post_ack",    32'(ack),  32'd0);
        tick(3);
        check("r_post3_busy",  32'(busy),     32'd0);
        check("r_post3_start", 32'(dp_start), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
